pst_stim_seq: RTL and testbench

Programmable stimulus sequencer driving the four input currents (`cur0..cur3`) of `pst_brain_v2`, one pattern per gamma window. Replaces hand-written bench loops with a hardware sequence that can run on-chip or in regression. It also counts how often the brain's `winner` equals a target pair, sampled once per window. It sits upstream of the brain and reads the brain's winner back.

---
 rtl/pst_stim_seq.sv | 184 ++++++++++++++++++
 tb/tb_pst_stim_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pst_stim_seq.sv
// pst_stim_seq: programmable stimulus sequencer for pst_brain_v2.
// Drives cur0..cur3 with one pattern per gamma window of TICK_LEN clocks and
// counts windows in which the brain winner matches TARGET_WIN.
// Optional feature macro: PST_STIM_DITHER_EN adds LFSR dither to the currents.
module pst_stim_seq #(
  parameter int unsigned TICK_LEN   = 256,
  parameter int unsigned BLOCK_LEN  = 4,
  parameter logic [2:0]  TARGET_WIN = 3'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] mode,
  input  logic [7:0] n_ticks,
  input  logic [2:0] winner_in,
  output logic [7:0] cur0,
  output logic [7:0] cur1,
  output logic [7:0] cur2,
  output logic [7:0] cur3,
  output logic       busy,
  output logic       done,
  output logic       tick_pulse,
  output logic [7:0] tick_idx,
  output logic [7:0] win_cnt
);

  localparam int unsigned CNT_W = $clog2(TICK_LEN);
  localparam int unsigned BLK_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_LEN - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLOCK_LEN - 1);

  // Patterns packed as {cur0, cur1, cur2, cur3}
  localparam logic [31:0] PAT_A   = {8'd200, 8'd180, 8'd5,   8'd8};
  localparam logic [31:0] PAT_B   = {8'd5,   8'd8,   8'd200, 8'd180};
  localparam logic [31:0] PAT_AMB = {8'd200, 8'd20,  8'd195, 8'd180};
  localparam logic [31:0] PAT_Q   = '0;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [2:0]       mode_r;
  logic [7:0]       n_ticks_r;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       tick_idx_r;
  logic [7:0]       win_cnt_r;
  logic [BLK_W-1:0] blk_cnt, blk_cnt_nxt;
  logic             blk_odd, blk_odd_nxt;
  logic [31:0]      cur_r, cur_nxt, pat;
  logic [2:0]       pat_mode;
  logic [7:0]       idx_nxt;
  logic             accept, load_first, window_end, last_window, advance;

  function automatic logic [31:0] pattern(input logic [2:0] m,
                                          input logic idx_odd,
                                          input logic blk_is_odd);
    case (m)
      3'd0:    return PAT_A;
      3'd1:    return PAT_B;
      3'd2:    return PAT_AMB;
      3'd3:    return idx_odd ? PAT_B : PAT_A;
      3'd4:    return blk_is_odd ? PAT_B : PAT_A;
      default: return PAT_Q;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and control strobes
  always_comb begin
    state_nxt   = state;
    accept      = (state == S_IDLE) && start;
    load_first  = accept && (n_ticks != '0);
    window_end  = (state == S_RUN) && (cnt == CNT_LAST);
    last_window = (tick_idx_r == (n_ticks_r - 8'd1));
    advance     = window_end && !last_window;
    busy        = (state == S_RUN);
    done        = (state == S_DONE);
    tick_pulse  = window_end;
    case (state)
      S_IDLE: if (start) state_nxt = (n_ticks != '0) ? S_RUN : S_DONE;
      S_RUN:  if (window_end && last_window) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Pattern for the window about to start (first window or next window);
  // block parity is tracked with a small counter instead of dividing tick_idx
  always_comb begin
    pat_mode    = mode;
    idx_nxt     = '0;
    blk_cnt_nxt = '0;
    blk_odd_nxt = 1'b0;
    if (!load_first) begin
      pat_mode = mode_r;
      idx_nxt  = tick_idx_r + 8'd1;
      if (blk_cnt == BLK_LAST) begin
        blk_cnt_nxt = '0;
        blk_odd_nxt = ~blk_odd;
      end else begin
        blk_cnt_nxt = blk_cnt + BLK_W'(1);
        blk_odd_nxt = blk_odd;
      end
    end
    pat = pattern(pat_mode, idx_nxt[0], blk_odd_nxt);
  end

`ifdef PST_STIM_DITHER_EN
  logic [7:0] lfsr, lfsr_win;

  function automatic logic [7:0] dith(input logic [7:0] c, input logic [2:0] d);
    logic [8:0] s;
    s = {1'b0, c} + {6'b0, d};
    if (c == '0) return '0;
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // Dither value for the starting window: seed on the first window, one step otherwise
  always_comb begin
    lfsr_win = load_first ? 8'hA5 : {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    cur_nxt  = {dith(pat[31:24], lfsr_win[2:0]), dith(pat[23:16], lfsr_win[2:0]),
                dith(pat[15:8],  lfsr_win[2:0]), dith(pat[7:0],   lfsr_win[2:0])};
  end

  // LFSR: reseeded on reset and accepted start, stepped once per later window
  always_ff @(posedge clk) begin
    if (rst)          lfsr <= 8'hA5;
    else if (accept)  lfsr <= 8'hA5;
    else if (advance) lfsr <= lfsr_win;
  end
`else
  // Currents are the exact pattern constants
  always_comb begin
    cur_nxt = pat;
  end
`endif

  // Run datapath: window counter, window index, winner count and currents
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r     <= '0;
      n_ticks_r  <= '0;
      cnt        <= '0;
      tick_idx_r <= '0;
      win_cnt_r  <= '0;
      blk_cnt    <= '0;
      blk_odd    <= 1'b0;
      cur_r      <= '0;
    end else begin
      if (accept) begin
        win_cnt_r <= '0;
        if (n_ticks != '0) begin
          mode_r     <= mode;
          n_ticks_r  <= n_ticks;
          cnt        <= '0;
          tick_idx_r <= '0;
        end
      end else if (window_end) begin
        if ((winner_in == TARGET_WIN) && (win_cnt_r != 8'hFF))
          win_cnt_r <= win_cnt_r + 8'd1;
        if (!last_window) begin
          cnt        <= '0;
          tick_idx_r <= idx_nxt;
        end
      end else if (state == S_RUN) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (load_first || advance) begin
        cur_r   <= cur_nxt;
        blk_cnt <= blk_cnt_nxt;
        blk_odd <= blk_odd_nxt;
      end
    end
  end

  assign {cur0, cur1, cur2, cur3} = cur_r;
  assign tick_idx = tick_idx_r;
  assign win_cnt  = win_cnt_r;

endmodule

// File: tb/tb_pst_stim_seq.sv
// tb_pst_stim_seq: directed self-checking bench for pst_stim_seq
// (TICK_LEN=256, BLOCK_LEN=2, TARGET_WIN=0, dither build macro undefined).
module tb_pst_stim_seq;

  localparam int TICK = 256;
  localparam int BLK  = 2;

  localparam logic [31:0] PAT_A   = {8'd200, 8'd180, 8'd5,   8'd8};
  localparam logic [31:0] PAT_B   = {8'd5,   8'd8,   8'd200, 8'd180};
  localparam logic [31:0] PAT_AMB = {8'd200, 8'd20,  8'd195, 8'd180};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] mode = '0;
  logic [7:0] n_ticks = '0;
  logic [2:0] winner_in = 3'd1;
  logic [7:0] cur0, cur1, cur2, cur3;
  logic       busy, done, tick_pulse;
  logic [7:0] tick_idx, win_cnt;
  logic [31:0] cur_all;

  int n_tests = 0;
  int n_fail  = 0;

  pst_stim_seq #(.TICK_LEN(TICK), .BLOCK_LEN(BLK), .TARGET_WIN(3'd0)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .n_ticks(n_ticks),
    .winner_in(winner_in), .cur0(cur0), .cur1(cur1), .cur2(cur2), .cur3(cur3),
    .busy(busy), .done(done), .tick_pulse(tick_pulse), .tick_idx(tick_idx),
    .win_cnt(win_cnt)
  );

  assign cur_all = {cur0, cur1, cur2, cur3};

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_pat(input logic [2:0] m, input int j);
    case (m)
      3'd0:    return PAT_A;
      3'd1:    return PAT_B;
      3'd2:    return PAT_AMB;
      3'd3:    return (j % 2 == 1) ? PAT_B : PAT_A;
      3'd4:    return ((j / BLK) % 2 == 1) ? PAT_B : PAT_A;
      default: return '0;
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, " cur"},        cur_all, 32'd0);
    check_eq({tag, " busy"},       32'(busy), 32'd0);
    check_eq({tag, " done"},       32'(done), 32'd0);
    check_eq({tag, " tick_pulse"}, 32'(tick_pulse), 32'd0);
    check_eq({tag, " tick_idx"},   32'(tick_idx), 32'd0);
    check_eq({tag, " win_cnt"},    32'(win_cnt), 32'd0);
  endtask

  // One complete run; window j sees a target winner when all_hit or mask[j].
  // poke_t >= 0 pulses start (with different mode/n_ticks) at that run offset.
  task automatic run_and_check(input string tag, input logic [2:0] m, input int n,
                               input logic [7:0] mask, input bit all_hit, input int poke_t);
    int  total, busy_n, done_n, tp_bad, exp_win, j;
    bit  hit, tp_exp;
    total   = n * TICK;
    busy_n  = 0;
    done_n  = 0;
    tp_bad  = 0;
    exp_win = 0;
    mode    = m;
    n_ticks = 8'(n);
    start   = 1'b1;
    step();
    start   = 1'b0;
    for (int t = 0; t <= total + 1; t++) begin
      if (t < total && (t % TICK) == 0) begin
        j = t / TICK;
        check_eq($sformatf("%s cur w%0d", tag, j), cur_all, exp_pat(m, j));
        check_eq($sformatf("%s tick_idx w%0d", tag, j), 32'(tick_idx), 32'(j));
        hit = all_hit || (j < 8 && mask[j]);
        winner_in = hit ? 3'd0 : 3'd1;
        if (hit) exp_win++;
      end
      if (busy) busy_n++;
      if (done) done_n++;
      tp_exp = (t < total) && ((t % TICK) == TICK - 1);
      if (tick_pulse !== tp_exp) tp_bad++;
      if (t == total) begin
        check_eq({tag, " done at end"}, 32'(done), 32'd1);
        check_eq({tag, " win_cnt at done"}, 32'(win_cnt), 32'(exp_win));
      end
      if (t == poke_t) begin
        start   = 1'b1;
        mode    = 3'd2;
        n_ticks = 8'd9;
      end else begin
        start   = 1'b0;
        mode    = m;
        n_ticks = 8'(n);
      end
      if (t != total + 1) step();
    end
    check_eq({tag, " busy cycles"}, 32'(busy_n), 32'(total));
    check_eq({tag, " done pulses"}, 32'(done_n), 32'd1);
    check_eq({tag, " tick_pulse misplaced"}, 32'(tp_bad), 32'd0);
    check_eq({tag, " busy after"}, 32'(busy), 32'd0);
    check_eq({tag, " tick_idx after"}, 32'(tick_idx), 32'(n - 1));
    check_eq({tag, " win_cnt held"}, 32'(win_cnt), 32'(exp_win));
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    run_and_check("m0",  3'd0, 3, 8'h07, 1'b0, -1);
    run_and_check("m3",  3'd3, 4, 8'h00, 1'b0, -1);
    run_and_check("m4",  3'd4, 8, 8'h55, 1'b0, -1);
    run_and_check("win", 3'd2, 4, 8'h05, 1'b0, -1);

    // zero-length run: immediate done, currents keep AMB, win_cnt cleared
    mode    = 3'd0;
    n_ticks = 8'd0;
    start   = 1'b1;
    step();
    start   = 1'b0;
    check_eq("zero done", 32'(done), 32'd1);
    check_eq("zero busy", 32'(busy), 32'd0);
    check_eq("zero cur", cur_all, PAT_AMB);
    check_eq("zero win_cnt", 32'(win_cnt), 32'd0);
    step();
    check_eq("zero done fall", 32'(done), 32'd0);
    check_eq("zero busy after", 32'(busy), 32'd0);
    check_eq("zero cur after", cur_all, PAT_AMB);

    run_and_check("poke", 3'd1, 2, 8'h02, 1'b0, 300);
    run_and_check("q",    3'd6, 1, 8'h01, 1'b0, -1);

    // reset in window 1, cycle 100, with a simultaneous start
    mode    = 3'd0;
    n_ticks = 8'd3;
    start   = 1'b1;
    step();
    start   = 1'b0;
    repeat (TICK + 100) step();
    check_eq("pre-rst busy", 32'(busy), 32'd1);
    check_eq("pre-rst tick_idx", 32'(tick_idx), 32'd1);
    rst   = 1'b1;
    start = 1'b1;
    step();
    check_all_zero("mid-rst");
    rst   = 1'b0;
    start = 1'b0;
    step();
    check_eq("post-rst busy", 32'(busy), 32'd0);
    check_eq("post-rst cur", cur_all, 32'd0);
    run_and_check("after rst", 3'd1, 1, 8'h00, 1'b0, -1);

    run_and_check("sat", 3'd0, 255, 8'h00, 1'b1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
